// File: rtl/keys_debounce_pkg.sv
// Shared helpers for the key debouncer: released-level lookup and the
// per-key stability counter width.
package keys_debounce_pkg;

  function automatic logic released_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

  function automatic int cnt_width(input int stable_cnt);
    return (stable_cnt > 1) ? $clog2(stable_cnt) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchroniser, stability counter and debounced output flop.
// flip_o is high in the cycle whose rising edge will toggle key_o.
module key_debounce_cell
  import keys_debounce_pkg::*;
#(
  parameter int STABLE_CNT = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic key_i,
  output logic key_o,
  output logic flip_o
);

  localparam int             CW      = cnt_width(STABLE_CNT);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CNT - 1);
  localparam logic           REL_LVL = released_level(ACTIVE_LOW);

  logic          s1_q, s2_q;
  logic          key_q, key_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed;
  logic          flip;

  // Normalise to "pressed" so the filter below is polarity-agnostic.
  assign pressed = ACTIVE_LOW ? ~s2_q : s2_q;

  always_comb begin
    key_d = key_q;
    cnt_d = '0;
    flip  = 1'b0;
    if (pressed != key_q) begin
      if (cnt_q == CNT_MAX) begin
        key_d = pressed;
        flip  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q  <= REL_LVL;
      s2_q  <= REL_LVL;
      cnt_q <= '0;
      key_q <= 1'b0;
    end else begin
      s1_q  <= key_i;
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
      key_q <= key_d;
    end
  end

  assign key_o  = key_q;
  assign flip_o = flip;

endmodule

// File: rtl/keys_debounce.sv
// Bank of independent key debouncers with a registered any-key-changed strobe.
module keys_debounce
  import keys_debounce_pkg::*;
#(
  parameter int NUM_KEYS   = 61,
  parameter int STABLE_CNT = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [NUM_KEYS-1:0] keys_i,
  output logic [NUM_KEYS-1:0] keys_o,
  output logic                keys_changed_o
);

  logic [NUM_KEYS-1:0] flip_vec;
  logic                changed_q, changed_d;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce_cell #(
      .STABLE_CNT (STABLE_CNT),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_cell (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .key_i   (keys_i[k]),
      .key_o   (keys_o[k]),
      .flip_o  (flip_vec[k])
    );
  end

  // Strobe lands on the same edge the flipping keys_o bits update.
  assign changed_d = |flip_vec;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign keys_changed_o = changed_q;

endmodule

// File: tb/tb_keys_debounce.sv
// Scoreboard bench for keys_debounce: default instance plus an
// ACTIVE_LOW=0 / STABLE_CNT=2 variant.
module tb_keys_debounce;

  typedef struct {
    int          cyc;
    logic [60:0] keys;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [3:0] keys;
  } exp2_t;

  logic        clk;
  logic        rst_n;
  logic [60:0] keys_i;
  logic [60:0] keys_o;
  logic        keys_changed;
  logic [3:0]  keys2_i;
  logic [3:0]  keys2_o;
  logic        keys2_changed;

  int    cyc;
  int    vectors;
  int    fails;
  exp_t  q1[$];
  exp2_t q2[$];
  logic [60:0] model1;
  logic [3:0]  model2;
  bit    done;

  keys_debounce dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .keys_i         (keys_i),
    .keys_o         (keys_o),
    .keys_changed_o (keys_changed)
  );

  keys_debounce #(
    .NUM_KEYS   (4),
    .STABLE_CNT (2),
    .ACTIVE_LOW (1'b0)
  ) dut2 (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .keys_i         (keys2_i),
    .keys_o         (keys2_o),
    .keys_changed_o (keys2_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [60:0] act, input logic [60:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected flip for the default instance: mask toggles at edge base+6.
  task automatic push1(input int base, input logic [60:0] mask);
    exp_t e;
    model1 = model1 ^ mask;
    e.cyc  = base + 6;
    e.keys = model1;
    q1.push_back(e);
  endtask

  task automatic push2(input int base, input logic [3:0] mask);
    exp2_t e;
    model2 = model2 ^ mask;
    e.cyc  = base + 4;
    e.keys = model2;
    q2.push_back(e);
  endtask

  // Monitor for the default instance.
  initial begin : mon1
    logic [60:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (rst_n) begin
        if (keys_changed) begin
          vectors++;
          if (q1.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pulse: keys_o %h at cyc %0d, none expected", keys_o, cyc);
          end else begin
            e = q1.pop_front();
            if (e.cyc != cyc || e.keys !== keys_o) begin
              fails++;
              $display("FAIL flip: got keys_o %h at cyc %0d expected %h at cyc %0d",
                       keys_o, cyc, e.keys, e.cyc);
            end
          end
        end else if (keys_o !== prev) begin
          vectors++;
          fails++;
          $display("FAIL silent_flip: keys_o %h was %h, no strobe (cyc %0d)", keys_o, prev, cyc);
        end
      end
      prev = keys_o;
    end
  end

  // Monitor for the variant instance.
  initial begin : mon2
    logic [3:0] prev;
    exp2_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (rst_n) begin
        if (keys2_changed) begin
          vectors++;
          if (q2.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pulse2: keys_o %h at cyc %0d, none expected", keys2_o, cyc);
          end else begin
            e = q2.pop_front();
            if (e.cyc != cyc || e.keys !== keys2_o) begin
              fails++;
              $display("FAIL flip2: got keys_o %h at cyc %0d expected %h at cyc %0d",
                       keys2_o, cyc, e.keys, e.cyc);
            end
          end
        end else if (keys2_o !== prev) begin
          vectors++;
          fails++;
          $display("FAIL silent_flip2: keys_o %h was %h, no strobe (cyc %0d)", keys2_o, prev, cyc);
        end
      end
      prev = keys2_o;
    end
  end

  initial begin : stim
    int b;
    logic [60:0] m;
    done    = 1'b0;
    vectors = 0;
    fails   = 0;
    model1  = '0;
    model2  = '0;
    rst_n   = 1'b0;
    keys_i  = '1;
    keys2_i = '0;

    // Reset value, then 20 quiet cycles after release.
    repeat (3) @(negedge clk);
    chk("rst_keys_o", keys_o, '0);
    chk("rst_changed", 61'(keys_changed), '0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_keys_o", keys_o, '0);
      chk("idle_changed", 61'(keys_changed), '0);
    end

    // Clean press and release of key 5.
    m = '0; m[5] = 1'b1;
    keys_i[5] = 1'b0; b = cyc; push1(b, m);
    repeat (10) @(negedge clk);
    keys_i[5] = 1'b1; b = cyc; push1(b, m);
    repeat (10) @(negedge clk);

    // Glitch: 3 samples low.
    keys_i[0] = 1'b0;
    repeat (3) @(negedge clk);
    keys_i[0] = 1'b1;
    repeat (8) @(negedge clk);
    // Glitch: 3 low / 1 high / 3 low.
    keys_i[0] = 1'b0;
    repeat (3) @(negedge clk);
    keys_i[0] = 1'b1;
    @(negedge clk);
    keys_i[0] = 1'b0;
    repeat (3) @(negedge clk);
    keys_i[0] = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_keys_o", keys_o, '0);

    // Simultaneous press/release of keys 0, 30, 60.
    m = '0; m[0] = 1'b1; m[30] = 1'b1; m[60] = 1'b1;
    keys_i = keys_i & ~m; b = cyc; push1(b, m);
    repeat (10) @(negedge clk);
    keys_i = keys_i | m; b = cyc; push1(b, m);
    repeat (10) @(negedge clk);

    // Reset with key 10 mid-filter (count 2), key held through reset.
    keys_i[10] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_keys_o", keys_o, '0);
    chk("midrst_changed", 61'(keys_changed), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m = '0; m[10] = 1'b1;
    b = cyc; push1(b, m);
    repeat (10) @(negedge clk);
    keys_i[10] = 1'b1; b = cyc; push1(b, m);
    repeat (10) @(negedge clk);

    // Variant instance: active-high input, STABLE_CNT=2.
    keys2_i[1] = 1'b1; b = cyc; push2(b, 4'b0010);
    repeat (8) @(negedge clk);
    keys2_i[1] = 1'b0; b = cyc; push2(b, 4'b0010);
    repeat (8) @(negedge clk);

    chk("q1_drained", 61'(q1.size()), '0);
    chk("q2_drained", 61'(q2.size()), '0);
    chk("final_keys_o", keys_o, '0);
    done = 1'b1;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/keys_debounce.md
# keys_debounce

Debounces a bank of raw mechanical key-switch inputs into clean, synchronous, active-high "pressed" flags. It sits between the keyboard matrix pins and the SPI key-register mux. It runs on the slow debounce clock produced by the top-level frequency divider. Each key is synchronised and filtered independently. A single-cycle change strobe flags any debounced transition.

## Interface
- NUM_KEYS, default 61: number of key inputs (≥1).
- STABLE_CNT, default 4: consecutive equal samples required to accept a new level (≥2).
- ACTIVE_LOW, default 1: 1 means a raw input at 0 is pressed; 0 means a raw input at 1 is pressed.
- clk_i, input, 1: debounce sample clock. One clock domain; all state changes on its rising edge.
- rst_n_i, input, 1: reset. Asynchronous, active-low.
- keys_i, input, NUM_KEYS: raw switch levels. Asynchronous to clk_i.
- keys_o, output, NUM_KEYS: debounced state. 1 means pressed. Registered.
- keys_changed_o, output, 1: high for one cycle after any keys_o bit flips. Registered.

## Operation
- Per key, a 2-flop synchroniser (s1, s2) captures keys_i[n].
- The synchronised level is normalised to "pressed": p = ACTIVE_LOW ? ~s2 : s2.
- Per key, a counter cnt of width $clog2(STABLE_CNT) compares p against keys_o[n] every cycle:
  - Match: cnt <= 0.
  - Mismatch and cnt == STABLE_CNT-1: keys_o[n] <= p and cnt <= 0.
  - Mismatch otherwise: cnt <= cnt+1.
- Result: a new level is accepted only after STABLE_CNT consecutive mismatching samples. Any shorter glitch is discarded and its counter cleared.
- Keys are fully independent. Any number of keys may flip on the same edge.
- keys_changed_o <= |(flip vector) on each edge. It is a single-cycle pulse per flipping edge. Back-to-back flips on consecutive edges give consecutive pulses.
- Reset values, applied asynchronously:
  - s1 and s2 take the released level (ACTIVE_LOW ? 1 : 0).
  - cnt = 0.
  - keys_o = 0.
  - keys_changed_o = 0.
- Reset mid-filter discards partial counts. After release, the filter restarts from the released state. A key held pressed through reset re-appears after the full latency.

## Timing
- Input change settles before edge 1.
- Edge 1: s1 captures. Edge 2: s2 captures.
- Edges 3 … 2+STABLE_CNT: mismatch counted.
- keys_o flips at edge 2+STABLE_CNT, which is edge 6 for the default. keys_changed_o rises on the same edge and falls on the next edge.
- A pulse of up to STABLE_CNT-1 samples (after synchronisation) never reaches keys_o.
- Release follows the same latency as press.
- Counter wrap: the counter never exceeds STABLE_CNT-1. No overflow is possible.
- No combinational path from keys_i or rst_n_i to the outputs, except the asynchronous reset clear.

## Structure
- Shared package: a function returning the released level for a given ACTIVE_LOW, and the counter width derivation. No typedefs are needed.
- One sub-module, key_debounce_cell:
  - Contains the synchroniser, counter, and output flop for one key.
  - Has a flip output.
  - Instantiated NUM_KEYS times by a generate loop.
- The top level ORs the flip outputs into keys_changed_o.
- No clock generation inside. The clock is supplied by the top level (PLL via global buffer, then divider).

## Test plan
- Reset value:
  - Stimulus: assert rst_n_i with keys_i all ones (ACTIVE_LOW=1).
  - Required: keys_o = 0 and keys_changed_o = 0. These stay unchanged for 20 cycles after release.
- Clean press:
  - Stimulus: drive keys_i[5]=0 before edge 1 and hold.
  - Required: keys_o[5] goes 1 exactly at edge 6, and keys_changed_o pulses one cycle. keys_o[5] releases at edge 6 after keys_i[5] returns to 1.
- Glitch rejection:
  - Stimulus: keys_i[0]=0 for 3 cycles, then 1.
  - Required: keys_o[0] stays 0 and keys_changed_o never pulses.
  - Stimulus: a 3-low/1-high/3-low sequence.
  - Required: still no flip, because the counter clears on the match.
- Simultaneous keys:
  - Stimulus: keys 0, 30, and 60 pressed on the same edge.
  - Required: all three bits set on the same edge, with a single one-cycle keys_changed_o pulse.
- Reset mid-operation:
  - Stimulus: press key 10, assert rst_n_i at count 2, release reset with the key still held.
  - Required: keys_o[10] = 0 immediately, and it becomes 1 six edges after reset release.
- Parameter variant:
  - Stimulus: ACTIVE_LOW=0, STABLE_CNT=2, keys_i[1]=1.
  - Required: keys_o[1]=1 at edge 4.
